// File: rtl/phoneme_sample_player.sv
`default_nettype none
// ============================================================================
//  Module   : phoneme_sample_player
//  Purpose  : Plays one phoneme on request from the phoneme sequencer. A
//             rising edge on phoneme_valid starts playback. The block reads
//             the phoneme's start and end word addresses from a table in
//             flash. It then streams the packed 8-bit samples, four per
//             32-bit word, one sample per sample_tick. When playback ends it
//             pulses phoneme_done.
//  Ports    : clk, reset_n               - clock, async active-low reset
//             phoneme_id, phoneme_valid  - request from the sequencer
//             sample_tick                - audio-rate enable
//             mem_addr, mem_read,
//             mem_waitrequest,
//             mem_readdata,
//             mem_readdatavalid          - flash read port (pipelined)
//             audio_out, audio_valid     - sample output and update strobe
//             busy, phoneme_done, bad_id - status back to the sequencer
//  Revision : 1.0 - initial release
// ============================================================================
module phoneme_sample_player #(
    parameter int ADDR_W       = 23,
    parameter int TABLE_BASE   = 0,
    parameter int NUM_PHONEMES = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        phoneme_id,
    input  logic              phoneme_valid,
    input  logic              sample_tick,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid,
    output logic [7:0]        audio_out,
    output logic              audio_valid,
    output logic              busy,
    output logic              phoneme_done,
    output logic              bad_id
);

    localparam logic [ADDR_W-1:0] c_table_base = ADDR_W'(TABLE_BASE);
    localparam logic [ADDR_W-1:0] c_addr_one   = ADDR_W'(1);
    localparam logic [31:0]       c_num_ids    = 32'(NUM_PHONEMES);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_RD_START   = 4'd1,
        S_WAIT_START = 4'd2,
        S_RD_END     = 4'd3,
        S_WAIT_END   = 4'd4,
        S_CHECK      = 4'd5,
        S_RD_DATA    = 4'd6,
        S_WAIT_DATA  = 4'd7,
        S_PLAY       = 4'd8,
        S_DONE       = 4'd9
    } state_t;

    state_t            r_state;
    logic              r_valid_q;   // previous phoneme_valid, for edge detection
    logic [ADDR_W-1:0] r_start;
    logic [ADDR_W-1:0] r_end;
    logic [ADDR_W-1:0] r_cur;       // word currently held in r_word
    logic [31:0]       r_word;
    logic [1:0]        r_byte;      // next byte lane of r_word to emit

    logic              w_req_edge;
    logic              w_id_ok;
    logic [ADDR_W-1:0] w_entry_addr;
    logic [7:0]        w_byte;

    assign w_req_edge   = phoneme_valid & ~r_valid_q;
    assign w_id_ok      = ({24'd0, phoneme_id} < c_num_ids);
    // Each table entry is two words: start address, then inclusive end address.
    assign w_entry_addr = c_table_base + ADDR_W'({phoneme_id, 1'b0});
    assign w_byte       = r_word[{r_byte, 3'b000} +: 8];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_valid_q    <= 1'b0;
            r_start      <= '0;
            r_end        <= '0;
            r_cur        <= '0;
            r_word       <= '0;
            r_byte       <= 2'd0;
            mem_addr     <= '0;
            mem_read     <= 1'b0;
            audio_out    <= 8'd0;
            audio_valid  <= 1'b0;
            busy         <= 1'b0;
            phoneme_done <= 1'b0;
            bad_id       <= 1'b0;
        end else begin
            // The edge detector always tracks the input, so edges that occur
            // while busy are consumed here and never replayed later.
            r_valid_q    <= phoneme_valid;
            audio_valid  <= 1'b0;
            phoneme_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_req_edge) begin
                        if (w_id_ok) begin
                            bad_id   <= 1'b0;
                            busy     <= 1'b1;
                            mem_addr <= w_entry_addr;
                            mem_read <= 1'b1;
                            r_state  <= S_RD_START;
                        end else begin
                            // A rejected id finishes at once without touching flash.
                            bad_id       <= 1'b1;
                            phoneme_done <= 1'b1;
                        end
                    end
                end

                S_RD_START: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        r_state  <= S_WAIT_START;
                    end
                end

                S_WAIT_START: begin
                    if (mem_readdatavalid) begin
                        r_start  <= mem_readdata[ADDR_W-1:0];
                        mem_addr <= mem_addr + c_addr_one;
                        mem_read <= 1'b1;
                        r_state  <= S_RD_END;
                    end
                end

                S_RD_END: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        r_state  <= S_WAIT_END;
                    end
                end

                S_WAIT_END: begin
                    if (mem_readdatavalid) begin
                        r_end   <= mem_readdata[ADDR_W-1:0];
                        r_state <= S_CHECK;
                    end
                end

                S_CHECK: begin
                    if (r_end < r_start) begin
                        // An empty range plays nothing.
                        busy         <= 1'b0;
                        phoneme_done <= 1'b1;
                        r_state      <= S_DONE;
                    end else begin
                        r_cur    <= r_start;
                        mem_addr <= r_start;
                        mem_read <= 1'b1;
                        r_state  <= S_RD_DATA;
                    end
                end

                S_RD_DATA: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        r_state  <= S_WAIT_DATA;
                    end
                end

                S_WAIT_DATA: begin
                    if (mem_readdatavalid) begin
                        r_word  <= mem_readdata;
                        r_byte  <= 2'd0;
                        r_state <= S_PLAY;
                    end
                end

                S_PLAY: begin
                    if (sample_tick) begin
                        audio_out   <= w_byte;
                        audio_valid <= 1'b1;
                        r_byte      <= r_byte + 2'd1;
                        if (r_byte == 2'd3) begin
                            // Compare before incrementing, so an end address
                            // of all-ones stops instead of wrapping to zero.
                            if (r_cur == r_end) begin
                                busy         <= 1'b0;
                                phoneme_done <= 1'b1;
                                r_state      <= S_DONE;
                            end else begin
                                r_cur    <= r_cur + c_addr_one;
                                mem_addr <= r_cur + c_addr_one;
                                mem_read <= 1'b1;
                                r_state  <= S_RD_DATA;
                            end
                        end
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phoneme_sample_player.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phoneme_sample_player
//  Purpose  : Self-checking bench for phoneme_sample_player. A flash responder
//             serves a small phoneme table. A model derives the expected read
//             addresses and samples from that table. A per-cycle monitor
//             compares the DUT against the model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phoneme_sample_player;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  phoneme_id = 8'd0;
    logic        phoneme_valid = 1'b0;
    logic        sample_tick = 1'b0;
    logic [22:0] mem_addr;
    logic        mem_read;
    logic        mem_waitrequest = 1'b0;
    logic [31:0] mem_readdata = 32'd0;
    logic        mem_readdatavalid = 1'b0;
    logic [7:0]  audio_out;
    logic        audio_valid;
    logic        busy;
    logic        phoneme_done;
    logic        bad_id;

    phoneme_sample_player #(
        .ADDR_W       (23),
        .TABLE_BASE   (0),
        .NUM_PHONEMES (64)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .phoneme_id        (phoneme_id),
        .phoneme_valid     (phoneme_valid),
        .sample_tick       (sample_tick),
        .mem_addr          (mem_addr),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .audio_out         (audio_out),
        .audio_valid       (audio_valid),
        .busy              (busy),
        .phoneme_done      (phoneme_done),
        .bad_id            (bad_id)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", name, got, exp);
        end
    endfunction

    // ---------------- flash contents and model ----------------
    logic [31:0] flash [int unsigned];

    function automatic logic [31:0] rd_flash(input logic [22:0] a);
        if (flash.exists(32'(a))) return flash[32'(a)];
        return 32'hDEAD_BEEF;
    endfunction

    logic [7:0]  exp_audio [$];
    logic [22:0] exp_addr  [$];

    // Expected reads and samples for an accepted id, from the table layout.
    task automatic load_model(input int id);
        logic [31:0] ws, we, w;
        logic [22:0] base, s, e, a;
        base = 23'(2 * id);
        ws = rd_flash(base);
        we = rd_flash(base + 23'd1);
        s = ws[22:0];
        e = we[22:0];
        exp_addr.push_back(base);
        exp_addr.push_back(base + 23'd1);
        if (e >= s) begin
            a = s;
            for (int guard = 0; guard < 64; guard++) begin
                w = rd_flash(a);
                exp_addr.push_back(a);
                for (int k = 0; k < 4; k++) exp_audio.push_back(w[8*k +: 8]);
                if (a == e) break;
                a = a + 23'd1;
            end
        end
    endtask

    // ---------------- sample tick: one pulse every 20 clocks ----------------
    int tick_cnt = 0;
    always @(negedge clk) begin
        sample_tick = (tick_cnt == 19);
        tick_cnt = (tick_cnt + 1) % 20;
    end

    // ---------------- flash responder, read latency 2 ----------------
    int wait_cfg = 0;
    int wait_left = 0;
    int pend_cnt = 0;
    logic [31:0] pend_data = 32'd0;
    always @(negedge clk) begin
        mem_readdatavalid = 1'b0;
        mem_readdata = 32'hDEAD_BEEF;
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                mem_readdatavalid = 1'b1;
                mem_readdata = pend_data;
            end
        end
        if (reset_n && mem_read) begin
            if (wait_left > 0) begin
                mem_waitrequest = 1'b1;
                wait_left--;
            end else begin
                mem_waitrequest = 1'b0;
                pend_data = rd_flash(mem_addr);
                pend_cnt = 2;
            end
        end else begin
            mem_waitrequest = 1'b0;
            wait_left = wait_cfg;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    int done_cnt = 0;
    int audio_cnt = 0;
    logic        prev_read = 1'b0;
    logic        prev_done = 1'b0;
    logic [22:0] prev_addr = 23'd0;
    always @(posedge clk) begin
        #1;
        if (!reset_n) begin
            prev_read = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_read) begin
                if (mem_waitrequest) begin
                    check("read_held", mem_read, 1'b1);
                    check("addr_held", mem_addr, prev_addr);
                end else begin
                    check("read_expected", exp_addr.size() > 0, 1'b1);
                    if (exp_addr.size() > 0) check("read_addr", prev_addr, exp_addr.pop_front());
                end
            end
            if (mem_read) check("busy_while_reading", busy, 1'b1);
            if (audio_valid) begin
                audio_cnt++;
                check("audio_on_tick", sample_tick, 1'b1);
                check("audio_expected", exp_audio.size() > 0, 1'b1);
                if (exp_audio.size() > 0) check("audio_sample", audio_out, exp_audio.pop_front());
            end
            if (phoneme_done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 1'b0);
                check("done_single_cycle", prev_done, 1'b0);
            end
            prev_read = mem_read;
            prev_addr = mem_addr;
            prev_done = phoneme_done;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic request(input logic [7:0] id);
        @(negedge clk);
        phoneme_valid = 1'b0;
        @(negedge clk);
        phoneme_id = id;
        phoneme_valid = 1'b1;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        repeat (30) @(negedge clk);
        check("done_count", done_cnt, target);
    endtask

    task automatic wait_audio(input int target, input int budget);
        int n = 0;
        while (audio_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("audio_progress", audio_cnt >= target, 1'b1);
    endtask

    task automatic check_model_drained(input string tag);
        check({tag, "_addr_left"}, exp_addr.size(), 0);
        check({tag, "_audio_left"}, exp_audio.size(), 0);
    endtask

    // ---------------- directed scenarios ----------------
    int d0, a0;
    initial begin
        // Table: entry 3 = 0x100..0x101 (upper bits of start word are junk),
        // entry 5 = empty range, entry 7 = single word at the top address.
        flash[6]         = 32'hA580_0100;
        flash[7]         = 32'h0000_0101;
        flash[32'h100]   = 32'h0403_0201;
        flash[32'h101]   = 32'h0807_0605;
        flash[10]        = 32'h0000_0200;
        flash[11]        = 32'h0000_01FF;
        flash[14]        = 32'h007F_FFFF;
        flash[15]        = 32'h007F_FFFF;
        flash[32'h7FFFFF] = 32'hDDCC_BBAA;

        repeat (3) @(negedge clk);
        check("rst_mem_addr", mem_addr, 23'd0);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_audio_out", audio_out, 8'd0);
        check("rst_audio_valid", audio_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", phoneme_done, 1'b0);
        check("rst_bad_id", bad_id, 1'b0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Basic playback of id 3, no stalls.
        load_model(3);
        d0 = done_cnt; a0 = audio_cnt;
        request(8'd3);
        @(posedge clk); #1;
        check("accept_busy", busy, 1'b1);
        check("accept_read", mem_read, 1'b1);
        check("accept_addr", mem_addr, 23'd6);
        wait_done(d0 + 1, 2000);
        check("s1_samples", audio_cnt - a0, 8);
        check("s1_last_sample", audio_out, 8'h08);
        check("s1_busy_after", busy, 1'b0);
        check_model_drained("s1");

        // Same playback with five wait cycles on every read.
        wait_cfg = 5;
        repeat (2) @(negedge clk);
        load_model(3);
        d0 = done_cnt; a0 = audio_cnt;
        request(8'd3);
        wait_done(d0 + 1, 2000);
        check("s2_samples", audio_cnt - a0, 8);
        check("s2_last_sample", audio_out, 8'h08);
        check_model_drained("s2");
        wait_cfg = 0;
        repeat (2) @(negedge clk);

        // Rejected id, then a good id clears bad_id.
        d0 = done_cnt;
        request(8'd64);
        check("bad_not_yet", phoneme_done, 1'b0);
        @(posedge clk); #1;
        check("bad_id_set", bad_id, 1'b1);
        check("bad_done_pulse", phoneme_done, 1'b1);
        check("bad_busy", busy, 1'b0);
        check("bad_no_read", mem_read, 1'b0);
        repeat (10) @(negedge clk);
        check("bad_id_sticky", bad_id, 1'b1);
        check("bad_done_count", done_cnt, d0 + 1);
        load_model(3);
        d0 = done_cnt; a0 = audio_cnt;
        request(8'd3);
        @(posedge clk); #1;
        check("bad_id_cleared", bad_id, 1'b0);
        wait_done(d0 + 1, 2000);
        check("s3_samples", audio_cnt - a0, 8);
        check_model_drained("s3");

        // Empty range: two table reads, no samples.
        load_model(5);
        d0 = done_cnt; a0 = audio_cnt;
        request(8'd5);
        wait_done(d0 + 1, 2000);
        check("s4_samples", audio_cnt - a0, 0);
        check("s4_audio_holds", audio_out, 8'h08);
        check_model_drained("s4");

        // End address of all-ones must stop, not wrap.
        load_model(7);
        d0 = done_cnt; a0 = audio_cnt;
        request(8'd7);
        wait_done(d0 + 1, 2000);
        check("s5_samples", audio_cnt - a0, 4);
        check("s5_last_sample", audio_out, 8'hDD);
        check_model_drained("s5");

        // A second edge during playback is ignored.
        load_model(3);
        d0 = done_cnt; a0 = audio_cnt;
        request(8'd3);
        wait_audio(a0 + 2, 1000);
        request(8'd5);
        wait_done(d0 + 1, 2000);
        check("s6_samples", audio_cnt - a0, 8);
        check_model_drained("s6");

        // Reset after the third sample, then replay from the first sample.
        load_model(3);
        a0 = audio_cnt;
        request(8'd3);
        wait_audio(a0 + 3, 1000);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_mem_read", mem_read, 1'b0);
        check("mid_rst_mem_addr", mem_addr, 23'd0);
        check("mid_rst_audio_out", audio_out, 8'd0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", phoneme_done, 1'b0);
        check("mid_rst_bad_id", bad_id, 1'b0);
        phoneme_valid = 1'b0;
        repeat (3) @(negedge clk);
        exp_addr.delete();
        exp_audio.delete();
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        load_model(3);
        d0 = done_cnt; a0 = audio_cnt;
        request(8'd3);
        wait_done(d0 + 1, 2000);
        check("s7_samples", audio_cnt - a0, 8);
        check("s7_last_sample", audio_out, 8'h08);
        check_model_drained("s7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
